sequential_binary_divider: RTL

SEQUENTIAL_BINARY_DIVIDER -- requirements
Module: sequential_binary_divider

---
 rtl/sequential_binary_divider.sv | 69 ++++++
 1 files changed

// File: rtl/sequential_binary_divider.sv
// sequential_binary_divider: restoring shift-subtract unsigned divider, one quotient bit per cycle
module sequential_binary_divider #(
  parameter int dp_width = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                Start,
  input  logic [dp_width-1:0] Dividend,
  input  logic [dp_width-1:0] Divisor,
  output logic [dp_width-1:0] Quotient,
  output logic [dp_width-1:0] Remainder,
  output logic                Ready,
  output logic                Done,
  output logic                Div_by_zero
);
  localparam int pw = $clog2(dp_width + 1);
  typedef enum logic {IDLE, CALC} state_t;
  state_t              state;
  logic [dp_width:0]   a, a_sh, a_nx;
  logic [dp_width-1:0] q, b, q_nx;
  logic [pw-1:0]       p;
  logic                dz, ge;
  assign Ready = (state == IDLE);
  // one restoring step: shift {A,Q} left, keep the difference only when it does not go negative
  always_comb begin
    a_sh = {a[dp_width-1:0], q[dp_width-1]};
    ge   = a_sh >= {1'b0, b};
    a_nx = ge ? a_sh - {1'b0, b} : a_sh;
    q_nx = {q[dp_width-2:0], ge};
  end
  // control FSM, datapath registers and registered results
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      b           <= '0;
      p           <= '0;
      dz          <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      Div_by_zero <= 1'b0;
      Done        <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (state == IDLE) begin
        if (Start) begin
          a     <= '0;
          q     <= Dividend;
          b     <= Divisor;
          p     <= pw'(dp_width);
          dz    <= (Divisor == '0);
          state <= CALC;
        end
      end else begin
        a <= a_nx;
        q <= q_nx;
        p <= p - pw'(1);
        if (p == pw'(1)) begin
          Quotient    <= q_nx;
          Remainder   <= a_nx[dp_width-1:0];
          Div_by_zero <= dz;
          Done        <= 1'b1;
          state       <= IDLE;
        end
      end
    end
  end
endmodule
